// File: rtl/mcycle_pkg.sv
// Shared types and op encodings for the multi-cycle multiply/divide unit.
package mcycle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10
  } state_t;

  localparam logic [1:0] MCYC_SMUL = 2'b00;
  localparam logic [1:0] MCYC_UMUL = 2'b01;
  localparam logic [1:0] MCYC_SDIV = 2'b10;
  localparam logic [1:0] MCYC_UDIV = 2'b11;

  function automatic logic isSigned(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic isDiv(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mcycle_unit_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
interface mcycle_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (output Start, MCycleOp, Operand1, Operand2,
                  input  Result1, Result2, Busy, Done);
  modport slave  (input  Start, MCycleOp, Operand1, Operand2,
                  output Result1, Result2, Busy, Done);
endinterface

// File: rtl/mcycle_sign_adjust.sv
// Conditional two's-complement: passes dataIn through, or its negation when negate is set.
module mcycle_sign_adjust #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] dataIn,
  input  logic             negate,
  output logic [WIDTH-1:0] dataOut
);

  // Negate or pass through.
  always_comb begin
    if (negate) dataOut = ~dataIn + WIDTH'(1);
    else        dataOut = dataIn;
  end

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle multiply (shift-add) / divide (restoring) unit on operand magnitudes.
// Optional macro MCYCLE_FAST_MUL_EN: multiplies use a single-cycle array product.
module mcycle_unit import mcycle_pkg::*; #(parameter int WIDTH = 32) (
  input logic         CLK,
  input logic         RESETn,
  mcycle_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_r;
  logic [1:0]       op_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r, mag_r, op1_r, result1_r, result2_r;
  logic             negRes_r, negRem_r, divZero_r, ovf_r, done_r;

  logic             signedIn_s, fastMul_s, lastIter_s;
  logic [WIDTH-1:0] magA_s, magB_s, iterHi_s, iterLo_s, stepHi_s, stepLo_s;
  logic [WIDTH-1:0] quotAdj_s, remAdj_s, res1_s, res2_s;
  logic [WIDTH:0]   sum_s, shifted_s;
  logic [2*WIDTH-1:0] prodAdj_s;

  assign signedIn_s = isSigned(bus.MCycleOp);
  assign bus.Busy   = (bus.Start && (state_r != COMPUTE)) || (state_r == COMPUTE);
  assign bus.Done   = done_r;
  assign bus.Result1 = result1_r;
  assign bus.Result2 = result2_r;

  mcycle_sign_adjust #(.WIDTH(WIDTH)) uMagA (
    .dataIn(bus.Operand1), .negate(signedIn_s & bus.Operand1[WIDTH-1]), .dataOut(magA_s));
  mcycle_sign_adjust #(.WIDTH(WIDTH)) uMagB (
    .dataIn(bus.Operand2), .negate(signedIn_s & bus.Operand2[WIDTH-1]), .dataOut(magB_s));
  mcycle_sign_adjust #(.WIDTH(2*WIDTH)) uProd (
    .dataIn({stepHi_s, stepLo_s}), .negate(negRes_r), .dataOut(prodAdj_s));
  mcycle_sign_adjust #(.WIDTH(WIDTH)) uQuot (
    .dataIn(stepLo_s), .negate(negRes_r), .dataOut(quotAdj_s));
  mcycle_sign_adjust #(.WIDTH(WIDTH)) uRem (
    .dataIn(stepHi_s), .negate(negRem_r), .dataOut(remAdj_s));

  // One iteration: hi:lo is the product accumulator, or remainder:dividend/quotient.
  always_comb begin
    sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mag_r} : {(WIDTH+1){1'b0}});
    shifted_s = {hi_r, lo_r[WIDTH-1]};
    if (isDiv(op_r)) begin
      if (shifted_s >= {1'b0, mag_r}) begin
        iterHi_s = WIDTH'(shifted_s - {1'b0, mag_r});
        iterLo_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        iterHi_s = shifted_s[WIDTH-1:0];
        iterLo_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      iterHi_s = sum_s[WIDTH:1];
      iterLo_s = {sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

`ifdef MCYCLE_FAST_MUL_EN
  logic [2*WIDTH-1:0] fastProd_s;
  assign fastMul_s  = ~isDiv(op_r);
  assign fastProd_s = {{WIDTH{1'b0}}, mag_r} * {{WIDTH{1'b0}}, lo_r};

  // Fast multiply bypasses the iterative step.
  always_comb begin
    if (fastMul_s) begin
      {stepHi_s, stepLo_s} = fastProd_s;
    end else begin
      stepHi_s = iterHi_s;
      stepLo_s = iterLo_s;
    end
  end
`else
  assign fastMul_s = 1'b0;

  // Every op goes through the iterative step.
  always_comb begin
    stepHi_s = iterHi_s;
    stepLo_s = iterLo_s;
  end
`endif

  assign lastIter_s = fastMul_s || (cnt_r == LAST_CNT);

  // Final result selection; special divide cases were flagged when the op was latched.
  always_comb begin
    if (!isDiv(op_r)) begin
      {res2_s, res1_s} = prodAdj_s;
    end else if (divZero_r) begin
      res1_s = {WIDTH{1'b1}};
      res2_s = op1_r;
    end else if (ovf_r) begin
      res1_s = op1_r;
      res2_s = {WIDTH{1'b0}};
    end else begin
      res1_s = quotAdj_s;
      res2_s = remAdj_s;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_r   <= IDLE;
      op_r      <= 2'b00;
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      mag_r     <= {WIDTH{1'b0}};
      op1_r     <= {WIDTH{1'b0}};
      result1_r <= {WIDTH{1'b0}};
      result2_r <= {WIDTH{1'b0}};
      negRes_r  <= 1'b0;
      negRem_r  <= 1'b0;
      divZero_r <= 1'b0;
      ovf_r     <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (bus.Start) begin
            state_r   <= COMPUTE;
            op_r      <= bus.MCycleOp;
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= isDiv(bus.MCycleOp) ? magA_s : magB_s;
            mag_r     <= isDiv(bus.MCycleOp) ? magB_s : magA_s;
            op1_r     <= bus.Operand1;
            negRes_r  <= signedIn_s & (bus.Operand1[WIDTH-1] ^ bus.Operand2[WIDTH-1]);
            negRem_r  <= signedIn_s & bus.Operand1[WIDTH-1];
            divZero_r <= (bus.Operand2 == {WIDTH{1'b0}});
            ovf_r     <= (bus.MCycleOp == MCYC_SDIV) && (bus.Operand1 == MOST_NEG) &&
                         (bus.Operand2 == {WIDTH{1'b1}});
          end else begin
            state_r <= IDLE;
          end
        end
        COMPUTE: begin
          hi_r  <= stepHi_s;
          lo_r  <= stepLo_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (lastIter_s) begin
            result1_r <= res1_s;
            result2_r <= res2_s;
            done_r    <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r <= COMPUTE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: cycle-level reference model plus directed and random ops.
module tb_mcycle_unit;
  import mcycle_pkg::*;

  localparam int W = 32;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mcycle_unit_if #(.WIDTH(W)) bus();

  mcycle_unit #(.WIDTH(W)) dut (.CLK(CLK), .RESETn(RESETn), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference results as {Result2, Result1}, straight from arithmetic.
  function automatic logic [63:0] refOp(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      MCYC_SMUL: return sa * sb;
      MCYC_UMUL: return {32'd0, a} * {32'd0, b};
      MCYC_SDIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int latOf(input logic [1:0] op);
`ifdef MCYCLE_FAST_MUL_EN
    if (!op[1]) return 1;
`endif
    return W;
  endfunction

  // Cycle-level expectation: remaining compute cycles, Done pulse and held results.
  int          remC = 0;
  logic        doneExp = 1'b0;
  logic        armed = 1'b0;
  logic [31:0] expR1 = 32'd0;
  logic [31:0] expR2 = 32'd0;
  logic [63:0] pend = 64'd0;

  initial forever begin
    @(negedge CLK);
    if (armed) begin
      check("busy", {63'd0, bus.Busy}, {63'd0, (remC > 0) || (bus.Start && remC == 0)});
      check("done", {63'd0, bus.Done}, {63'd0, doneExp});
      check("result1", {32'd0, bus.Result1}, {32'd0, expR1});
      check("result2", {32'd0, bus.Result2}, {32'd0, expR2});
    end
    if (!RESETn) begin
      remC = 0; doneExp = 1'b0; expR1 = 32'd0; expR2 = 32'd0; armed = 1'b1;
    end else if (remC > 0) begin
      remC--;
      doneExp = (remC == 0);
      if (remC == 0) begin
        expR1 = pend[31:0];
        expR2 = pend[63:32];
      end
    end else begin
      doneExp = 1'b0;
      if (bus.Start) begin
        remC = latOf(bus.MCycleOp);
        pend = refOp(bus.MCycleOp, bus.Operand1, bus.Operand2);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    tick();
    bus.Start = 1'b0;
  endtask

  // Wait (bounded) for Done; k0 is the cycle index (relative to Start) we are in now.
  task automatic waitDone(input string name, input int k0, input int expCyc,
                          input logic [31:0] e1, input logic [31:0] e2);
    int k;
    bit found;
    k = k0;
    found = 1'b0;
    while (!found && k <= k0 + W + 4) begin
      @(negedge CLK);
      if (bus.Done === 1'b1) found = 1'b1;
      else begin
        tick();
        k++;
      end
    end
    check({name, "_done_seen"}, {63'd0, found}, 64'd1);
    check({name, "_latency"}, 64'(k), 64'(expCyc));
    check({name, "_r1"}, {32'd0, bus.Result1}, {32'd0, e1});
    check({name, "_r2"}, {32'd0, bus.Result2}, {32'd0, e2});
    tick();
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(15));
      5: return 32'hFFFF_FFF0 | 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] e;
    logic [1:0]  op;
    logic [31:0] a, b;
    bus.Start = 1'b0;
    bus.MCycleOp = 2'b00;
    bus.Operand1 = 32'd0;
    bus.Operand2 = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_busy", {63'd0, bus.Busy}, 64'd0);
    check("reset_done", {63'd0, bus.Done}, 64'd0);
    check("reset_r1", {32'd0, bus.Result1}, 64'd0);
    check("reset_r2", {32'd0, bus.Result2}, 64'd0);
    RESETn = 1'b1;

    check("ref_smul", refOp(MCYC_SMUL, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
    check("ref_umul", refOp(MCYC_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    check("ref_sdiv", refOp(MCYC_SDIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("ref_udiv0", refOp(MCYC_UDIV, 32'd100, 32'd0), 64'h0000_0064_FFFF_FFFF);
    check("ref_ovf", refOp(MCYC_SDIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    tick();

    launch(MCYC_SMUL, 32'hFFFF_FFFD, 32'd7);
    waitDone("smul", 1, latOf(MCYC_SMUL) + 1, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
    launch(MCYC_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("umul", 1, latOf(MCYC_UMUL) + 1, 32'h0000_0001, 32'hFFFF_FFFE);
    launch(MCYC_SDIV, 32'hFFFF_FFF9, 32'd2);
    waitDone("sdiv", 1, W + 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    launch(MCYC_UDIV, 32'd100, 32'd7);
    waitDone("udiv", 1, W + 1, 32'd14, 32'd2);
    launch(MCYC_UDIV, 32'd100, 32'd0);
    waitDone("udiv_zero", 1, W + 1, 32'hFFFF_FFFF, 32'h0000_0064);
    launch(MCYC_SDIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("sdiv_ovf", 1, W + 1, 32'h8000_0000, 32'd0);
    launch(MCYC_SDIV, 32'hFFFF_FFF9, 32'd0);
    waitDone("sdiv_zero", 1, W + 1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

    // A Start during COMPUTE must be ignored.
    launch(MCYC_UDIV, 32'd100, 32'd7);
    repeat (4) tick();
    launch(MCYC_SMUL, 32'd5, 32'd5);
    waitDone("ignore_start", 6, W + 1, 32'd14, 32'd2);

    // Start in the Done cycle chains a new op.
    launch(MCYC_UDIV, 32'd100, 32'd7);
    repeat (W) tick();
    check("b2b_done", {63'd0, bus.Done}, 64'd1);
    check("b2b_r1", {32'd0, bus.Result1}, 64'd14);
    launch(MCYC_SDIV, 32'hFFFF_FFF9, 32'd2);
    waitDone("b2b_second", 1, W + 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    // Reset in cycle 10 of a multiply.
    launch(MCYC_UMUL, 32'd12345, 32'd678);
    repeat (9) tick();
    RESETn = 1'b0;
    tick();
    check("abort_busy", {63'd0, bus.Busy}, 64'd0);
    check("abort_done", {63'd0, bus.Done}, 64'd0);
    check("abort_r1", {32'd0, bus.Result1}, 64'd0);
    check("abort_r2", {32'd0, bus.Result2}, 64'd0);
    RESETn = 1'b1;
    tick();
    launch(MCYC_UMUL, 32'd12345, 32'd678);
    waitDone("after_abort", 1, latOf(MCYC_UMUL) + 1, 32'd8369910, 32'd0);

    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(3));
      a = pickOperand();
      b = pickOperand();
      e = refOp(op, a, b);
      repeat ($urandom_range(2)) tick();
      launch(op, a, b);
      waitDone("random", 1, latOf(op) + 1, e[31:0], e[63:32]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
